// File: rtl/inst_stim_gen_if.sv
// Handshake/bus bundle between the stimulus generator and its consumer.
interface inst_stim_gen_if;
  logic        start;
  logic [15:0] seed;
  logic [7:0]  num_inst;
  logic        mode;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] inst;
  logic [15:0] rand_data;
  logic        busy;
  logic        done;
  logic [7:0]  inst_cnt;

  // Generator side
  modport master (
    input  start, seed, num_inst, mode, out_ready,
    output out_valid, inst, rand_data, busy, done, inst_cnt
  );

  // Consumer / controller side
  modport slave (
    output start, seed, num_inst, mode, out_ready,
    input  out_valid, inst, rand_data, busy, done, inst_cnt
  );
endinterface

// File: rtl/inst_stim_gen.sv
// Stimulus source: emits (inst, rand_data) pairs from two seeded Galois LFSRs
// under a valid/ready handshake, num_inst pairs per run.
module inst_stim_gen #(
  parameter logic [15:0] SEED_FALLBACK_A = 16'hACE1,
  parameter logic [15:0] SEED_FALLBACK_B = 16'h531E
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_stim_gen_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [3:0]  OP_MAX = 4'd12;

  state_t      state_q, state_d;
  logic [15:0] lfsr_a_q, lfsr_b_q;
  logic [8:0]  remaining_q;       // 9 bits so a 256-pair run fits
  logic [3:0]  op_seq_q;
  logic        mode_q;
  logic [15:0] inst_q, rand_q;
  logic [7:0]  cnt_q;

  logic        xfer;
  logic        last_xfer;
  logic        load;
  logic [15:0] seed_a, seed_b;
  logic [15:0] lfsr_a_nx, lfsr_b_nx;
  logic [3:0]  op_seq_nx;
  logic        out_valid, busy, done;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? TAPS : 16'h0000);
  endfunction

  // Opcode folding keeps random opcodes in 0..12 (13..15 map to 0..2).
  function automatic logic [15:0] mk_inst(input logic md, input logic [3:0] seq,
                                          input logic [15:0] b);
    logic [3:0] op;
    if (md) op = (b[15:12] > OP_MAX) ? (b[15:12] - 4'd13) : b[15:12];
    else    op = seq;
    return {op, b[11:0]};
  endfunction

  assign seed_a    = (bus.seed == 16'h0000) ? SEED_FALLBACK_A : bus.seed;
  assign seed_b    = (~bus.seed == 16'h0000) ? SEED_FALLBACK_B : ~bus.seed;
  assign lfsr_a_nx = lfsr_step(lfsr_a_q);
  assign lfsr_b_nx = lfsr_step(lfsr_b_q);
  assign op_seq_nx = (op_seq_q == OP_MAX) ? 4'd0 : op_seq_q + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        xfer      = bus.out_ready;
        last_xfer = xfer && (remaining_q == 9'd1);
        if (last_xfer) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: seed load on start, advance on each transfer, hold otherwise.
  // The presented pair is not refreshed on the final transfer so the last
  // pair stays visible after the run ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a_q    <= 16'h0000;
      lfsr_b_q    <= 16'h0000;
      remaining_q <= 9'd0;
      op_seq_q    <= 4'd0;
      mode_q      <= 1'b0;
      inst_q      <= 16'h0000;
      rand_q      <= 16'h0000;
      cnt_q       <= 8'h00;
    end else if (load) begin
      lfsr_a_q    <= seed_a;
      lfsr_b_q    <= seed_b;
      mode_q      <= bus.mode;
      remaining_q <= (bus.num_inst == 8'd0) ? 9'd256 : {1'b0, bus.num_inst};
      op_seq_q    <= 4'd0;
      cnt_q       <= 8'h00;
      rand_q      <= seed_a;
      inst_q      <= mk_inst(bus.mode, 4'd0, seed_b);
    end else if (xfer) begin
      lfsr_a_q    <= lfsr_a_nx;
      lfsr_b_q    <= lfsr_b_nx;
      remaining_q <= remaining_q - 9'd1;
      op_seq_q    <= op_seq_nx;
      cnt_q       <= cnt_q + 8'd1;
      if (!last_xfer) begin
        rand_q <= lfsr_a_nx;
        inst_q <= mk_inst(mode_q, op_seq_nx, lfsr_b_nx);
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.inst      = inst_q;
  assign bus.rand_data = rand_q;
  assign bus.inst_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_stim_gen.sv
// Bench for inst_stim_gen: table of directed runs, randomized runs against a
// rule-level reference model, plus reset/restart sequences.
module tb_inst_stim_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_stim_gen_if bus ();

  inst_stim_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: expected pair stream for a run, straight from the rules.
  logic [15:0] exp_i[$];
  logic [15:0] exp_r[$];

  task automatic build_model(input logic [15:0] sd, input logic md, input int total);
    logic [15:0] a, b;
    int op;
    exp_i.delete();
    exp_r.delete();
    a = (sd == 16'h0000) ? 16'hACE1 : sd;
    b = (~sd == 16'h0000) ? 16'h531E : ~sd;
    for (int k = 0; k < total; k++) begin
      op = md ? (int'(b[15:12]) % 13) : (k % 13);
      exp_i.push_back({op[3:0], b[11:0]});
      exp_r.push_back(a);
      a = (a >> 1) ^ (a[0] ? 16'hB400 : 16'h0000);
      b = (b >> 1) ^ (b[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  // rdy: 0 always ready, 1 random, 2 five-cycle stall early in the run
  task automatic run_check(input logic [15:0] sd, input logic md, input logic [7:0] n,
                           input int rdy, input bit poke, input bit chk0,
                           input logic [15:0] i0, input logic [15:0] r0);
    int total, k, cyc, dones;
    bit rd;
    total = (n == 8'd0) ? 256 : int'(n);
    build_model(sd, md, total);
    @(negedge clk);
    bus.start = 1'b1; bus.seed = sd; bus.mode = md; bus.num_inst = n;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    if (chk0) begin
      chk("first_inst", {16'd0, bus.inst}, {16'd0, i0});
      chk("first_rand", {16'd0, bus.rand_data}, {16'd0, r0});
    end
    k = 0; cyc = 0; dones = 0;
    while (cyc < 3000) begin
      if (bus.done) begin
        dones++;
        chk("valid_in_done", {31'd0, bus.out_valid}, 32'd0);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
        break;
      end
      bus.start = 1'b0;
      if (poke && cyc == 3) begin
        bus.start = 1'b1; bus.seed = ~sd; bus.num_inst = 8'd1;
      end
      if (bus.out_valid) begin
        if (k >= total) chk("extra_transfer", k, total - 1);
        else begin
          chk("inst", {16'd0, bus.inst}, {16'd0, exp_i[k]});
          chk("rand", {16'd0, bus.rand_data}, {16'd0, exp_r[k]});
          chk("op_range", {31'd0, bus.inst[15:12] <= 4'd12}, 32'd1);
        end
        chk("inst_cnt", {24'd0, bus.inst_cnt}, k % 256);
        case (rdy)
          0:       rd = 1'b1;
          1:       rd = ($urandom % 4) != 0;
          default: rd = !(cyc >= 2 && cyc < 7);
        endcase
        bus.out_ready = rd;
        if (rd) k++;
      end else begin
        bus.out_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk("done_pulses", dones, 1);
    chk("transfers", k, total);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("final_cnt", {24'd0, bus.inst_cnt}, total % 256);
    chk("idle_inst_hold", {16'd0, bus.inst}, {16'd0, exp_i[total-1]});
    chk("idle_rand_hold", {16'd0, bus.rand_data}, {16'd0, exp_r[total-1]});
  endtask

  typedef struct {
    logic [15:0] seed;
    logic        mode;
    logic [7:0]  n;
    int          rdy;
    bit          poke;
    logic [15:0] i0;
    logic [15:0] r0;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'hACE1, 1'b0, 8'd3,  0, 1'b0, 16'h031E, 16'hACE1};
    vecs[1] = '{16'h0000, 1'b1, 8'd4,  0, 1'b0, 16'h2FFF, 16'hACE1};
    vecs[2] = '{16'hFFFF, 1'b0, 8'd2,  0, 1'b0, 16'h031E, 16'hFFFF};
    vecs[3] = '{16'h1234, 1'b0, 8'd20, 2, 1'b0, 16'h0DCB, 16'h1234};
    vecs[4] = '{16'hBEEF, 1'b1, 8'd7,  1, 1'b1, 16'h4110, 16'hBEEF};
    vecs[5] = '{16'h0001, 1'b0, 8'd0,  0, 1'b0, 16'h0FFE, 16'h0001};

    bus.start = 1'b0; bus.seed = 16'h0; bus.mode = 1'b0;
    bus.num_inst = 8'd0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_done",  {31'd0, bus.done}, 32'd0);
    chk("rst_inst",  {16'd0, bus.inst}, 32'd0);
    chk("rst_rand",  {16'd0, bus.rand_data}, 32'd0);
    chk("rst_cnt",   {24'd0, bus.inst_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 6; v++)
      run_check(vecs[v].seed, vecs[v].mode, vecs[v].n, vecs[v].rdy, vecs[v].poke,
                1'b1, vecs[v].i0, vecs[v].r0);

    // Second pair of the sequential reference run, hand-checked
    build_model(16'hACE1, 1'b0, 3);
    chk("ref_pair1_inst", {16'd0, exp_i[1]}, 32'h198F);
    chk("ref_pair1_rand", {16'd0, exp_r[1]}, 32'hE270);

    // Randomized runs
    for (int r = 0; r < 8; r++)
      run_check(16'($urandom), 1'($urandom), 8'($urandom_range(1, 40)), 1,
                1'($urandom), 1'b0, 16'h0, 16'h0);

    // Random-mode opcode range over >1000 transfers
    for (int r = 0; r < 4; r++)
      run_check(16'($urandom), 1'b1, 8'd0, 0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset mid-run after two transfers
    @(negedge clk);
    bus.start = 1'b1; bus.seed = 16'h5A5A; bus.mode = 1'b0; bus.num_inst = 8'd10;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cnt", {24'd0, bus.inst_cnt}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_inst",  {16'd0, bus.inst}, 32'd0);
    chk("mid_rst_rand",  {16'd0, bus.rand_data}, 32'd0);
    chk("mid_rst_cnt",   {24'd0, bus.inst_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_idle_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("post_rst_no_done",    {31'd0, bus.done}, 32'd0);
      chk("post_rst_cnt",        {24'd0, bus.inst_cnt}, 32'd0);
    end
    bus.out_ready = 1'b0;

    // Clean run after reset
    run_check(16'hACE1, 1'b0, 8'd3, 0, 1'b0, 1'b1, 16'h031E, 16'hACE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
